// File: rtl/vga_timing_gen_if.sv
// Control and raster bundle of vga_timing_gen: run request, config write port and timing outputs.
interface vga_timing_gen_if #(
  parameter int CW = 12
) ();
  logic          enable;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          hs;
  logic          vs;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          vblank;

  modport master (
    output enable, cfg_we, cfg_addr, cfg_data,
    input  hs, vs, active, x, y, line_start, frame_start, vblank
  );

  modport slave (
    input  enable, cfg_we, cfg_addr, cfg_data,
    output hs, vs, active, x, y, line_start, frame_start, vblank
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA/VESA raster timing generator; new timing fields take effect
// only on a frame boundary, or immediately while the raster is idle.
module vga_timing_gen #(
  parameter int CW     = 12,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input logic             clock,
  input logic             reset_n,
  vga_timing_gen_if.slave bus
);

  localparam int NW = CW + 2;

  typedef logic [CW-1:0] fld_t;
  typedef logic [NW-1:0] cnt_t;

  logic run;
  cnt_t h_cnt;
  cnt_t v_cnt;
  fld_t shd    [8];
  fld_t wrk    [8];
  fld_t shd_nx [8];

  function automatic fld_t dflt(input int idx);
    case (idx)
      0:       return fld_t'(H_ACT);
      1:       return fld_t'(H_FP);
      2:       return fld_t'(H_SYNC);
      3:       return fld_t'(H_BP);
      4:       return fld_t'(V_ACT);
      5:       return fld_t'(V_FP);
      6:       return fld_t'(V_SYNC);
      default: return fld_t'(V_BP);
    endcase
  endfunction

  // Zero writes are dropped so no field can collapse to an empty region.
  always_comb begin
    shd_nx = shd;
    if (bus.cfg_we && (bus.cfg_data != '0)) shd_nx[bus.cfg_addr] = bus.cfg_data;
  end

  cnt_t h_act, h_ss, h_se, h_tot;
  cnt_t v_act, v_ss, v_se, v_tot;
  logic h_last, v_last;

  assign h_act  = cnt_t'(wrk[0]);
  assign h_ss   = h_act + cnt_t'(wrk[1]);
  assign h_se   = h_ss + cnt_t'(wrk[2]);
  assign h_tot  = h_se + cnt_t'(wrk[3]);
  assign v_act  = cnt_t'(wrk[4]);
  assign v_ss   = v_act + cnt_t'(wrk[5]);
  assign v_se   = v_ss + cnt_t'(wrk[6]);
  assign v_tot  = v_se + cnt_t'(wrk[7]);
  assign h_last = (h_cnt >= h_tot - cnt_t'(1));
  assign v_last = (v_cnt >= v_tot - cnt_t'(1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        shd[i] <= dflt(i);
        wrk[i] <= dflt(i);
      end
    end else begin
      run <= bus.enable;
      shd <= shd_nx;
      if (!run) begin
        h_cnt <= '0;
        v_cnt <= '0;
        wrk   <= shd_nx;
      end else if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt <= '0;
          wrk   <= shd_nx;
        end else begin
          v_cnt <= v_cnt + cnt_t'(1);
        end
      end else begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
    end
  end

  logic act, hs_on, vs_on, ls;

  assign act   = run && (h_cnt < h_act) && (v_cnt < v_act);
  assign hs_on = run && (h_cnt >= h_ss) && (h_cnt < h_se);
  assign vs_on = run && (v_cnt >= v_ss) && (v_cnt < v_se);
  assign ls    = run && (h_cnt == '0);

  assign bus.active      = act;
  assign bus.x           = act ? h_cnt[CW-1:0] : '0;
  assign bus.y           = act ? v_cnt[CW-1:0] : '0;
  assign bus.hs          = hs_on ? HS_POL : ~HS_POL;
  assign bus.vs          = vs_on ? VS_POL : ~VS_POL;
  assign bus.line_start  = ls;
  assign bus.frame_start = ls && (v_cnt == '0);
  assign bus.vblank      = run && (v_cnt >= v_act);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-parameter instance checked every cycle against a frame-time
// model, plus a default-parameter instance checked over its first two lines.
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vga_timing_gen_if #(.CW(12)) s_if ();
  vga_timing_gen_if #(.CW(12)) d_if ();

  vga_timing_gen #(
    .CW(12), .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .clock(clock), .reset_n(reset_n), .bus(s_if.slave)
  );

  vga_timing_gen #(.CW(12)) u_def (
    .clock(clock), .reset_n(reset_n), .bus(d_if.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [29:0] pk(input logic hs, input logic vs, input logic a,
                                     input logic ls, input logic fs, input logic vb,
                                     input logic [11:0] x, input logic [11:0] y);
    return {hs, vs, a, ls, fs, vb, x, y};
  endfunction

  function automatic logic [29:0] pk_s();
    return pk(s_if.hs, s_if.vs, s_if.active, s_if.line_start, s_if.frame_start,
              s_if.vblank, s_if.x, s_if.y);
  endfunction

  // Reference model: position is time-within-frame; h/v come from division by the line length.
  localparam int S_DEF[8] = '{4, 1, 2, 1, 3, 1, 1, 1};
  int m_shd[8], m_wrk[8], m_nshd[8];
  bit m_run;
  int m_t;

  always @(posedge clock) begin
    int htot, vtot, h, v, hss, vss;
    bit a;
    if (!reset_n) begin
      m_shd = S_DEF; m_wrk = S_DEF; m_run = 0; m_t = 0;
    end else begin
      m_nshd = m_shd;
      if (s_if.cfg_we && s_if.cfg_data != 0) m_nshd[s_if.cfg_addr] = int'(s_if.cfg_data);
      htot = m_wrk[0] + m_wrk[1] + m_wrk[2] + m_wrk[3];
      vtot = m_wrk[4] + m_wrk[5] + m_wrk[6] + m_wrk[7];
      if (!m_run) begin
        m_t = 0; m_wrk = m_nshd;
      end else begin
        m_t++;
        if (m_t >= htot * vtot) begin m_t = 0; m_wrk = m_nshd; end
      end
      m_shd = m_nshd;
      m_run = s_if.enable;
    end
    #1;
    htot = m_wrk[0] + m_wrk[1] + m_wrk[2] + m_wrk[3];
    h    = m_t % htot;
    v    = m_t / htot;
    hss  = m_wrk[0] + m_wrk[1];
    vss  = m_wrk[4] + m_wrk[5];
    a    = m_run && h < m_wrk[0] && v < m_wrk[4];
    check("model", pk_s(),
          pk(m_run && h >= hss && h < hss + m_wrk[2], m_run && v >= vss && v < vss + m_wrk[6],
             a, m_run && h == 0, m_run && m_t == 0, m_run && v >= m_wrk[4],
             a ? 12'(h) : 12'd0, a ? 12'(v) : 12'd0));
  end

  typedef struct {
    bit en;
    int ex, ey;
    bit ea, ehs, evs, els, efs, evb;
  } vec_t;
  vec_t vecs[10];

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wait_xy(input int xx, input int yy);
    int k;
    for (k = 0; k < 200 && !(s_if.active && s_if.x == 12'(xx) && s_if.y == 12'(yy)); k++) step();
    check("wait_xy_found", (k < 200), 1);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [11:0] data);
    s_if.cfg_we = 1'b1; s_if.cfg_addr = addr; s_if.cfg_data = data;
    step();
    s_if.cfg_we = 1'b0;
  endtask

  task automatic measure_frame(output int len, output int n_act, output int n_vs,
                               output int n_vb, output int max_x, output int line_len);
    int k, n_ls;
    len = 0; n_act = 0; n_vs = 0; n_vb = 0; max_x = 0; line_len = 0; n_ls = 0;
    for (k = 0; k < 1000 && !s_if.frame_start; k++) step();
    check("wait_fs_found", s_if.frame_start, 1);
    if (!s_if.frame_start) return;
    for (k = 0; k < 1000; k++) begin
      if (s_if.line_start) n_ls++;
      if (n_ls == 1) line_len++;
      if (s_if.active) n_act++;
      if (s_if.vs) n_vs++;
      if (s_if.vblank) n_vb++;
      if (int'(s_if.x) > max_x) max_x = int'(s_if.x);
      len++;
      step();
      if (s_if.frame_start) break;
    end
  endtask

  initial begin
    int len, n_act, n_vs, n_vb, max_x, line_len, gap, hs_low, k;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 1, 0, 0, 1, 1, 0};
    vecs[2] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 2, 0, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 3, 0, 1, 0, 0, 0, 0, 0};
    vecs[5] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[8] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{1, 0, 1, 1, 0, 0, 1, 0, 0};

    s_if.enable = 0; s_if.cfg_we = 0; s_if.cfg_addr = 0; s_if.cfg_data = 0;
    d_if.enable = 0; d_if.cfg_we = 0; d_if.cfg_addr = 0; d_if.cfg_data = 0;
    repeat (3) step();
    check("reset_small", pk_s(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_def", pk(d_if.hs, d_if.vs, d_if.active, d_if.line_start, d_if.frame_start,
                          d_if.vblank, d_if.x, d_if.y), pk(1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clock); reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock); s_if.enable = vecs[i].en;
      step();
      check($sformatf("vec%0d", i), pk_s(),
            pk(vecs[i].ehs, vecs[i].evs, vecs[i].ea, vecs[i].els, vecs[i].efs, vecs[i].evb,
               12'(vecs[i].ex), 12'(vecs[i].ey)));
    end

    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    check("small_frame_len", len, 48);
    check("small_line_len", line_len, 8);
    check("small_active_cnt", n_act, 12);
    check("small_vblank_cnt", n_vb, 24);
    check("small_vs_cnt", n_vs, 8);

    wait_xy(2, 1);
    cfg_write(3'd0, 12'd6);
    for (k = 0; k < 50 && !s_if.line_start; k++) step();
    gap = 0;
    for (k = 0; k < 50; k++) begin step(); gap++; if (s_if.line_start) break; end
    check("hact_old_line_len", gap, 8);
    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    check("hact_new_frame_len", len, 60);
    check("hact_new_line_len", line_len, 10);
    check("hact_new_active_cnt", n_act, 18);
    check("hact_new_max_x", max_x, 5);
    cfg_write(3'd0, 12'd4);
    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    check("hact_restored_len", len, 48);

    cfg_write(3'd6, 12'd0);
    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    check("vsync_zero_vs_cnt", n_vs, 8);

    wait_xy(2, 1);
    s_if.enable = 1'b0;
    step();
    check("drop_idle", pk_s(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) step();
    s_if.enable = 1'b1;
    step();
    check("restart_fs", pk_s(), pk(0, 0, 1, 1, 1, 0, 0, 0));
    step();
    check("restart_x1", s_if.x, 1);

    wait_xy(1, 2);
    cfg_write(3'd0, 12'd6);
    reset_n = 1'b0;
    step();
    check("reset_mid_idle", pk_s(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    measure_frame(len, n_act, n_vs, n_vb, max_x, line_len);
    check("reset_revert_len", len, 48);
    check("reset_revert_line_len", line_len, 8);
    check("reset_revert_active", n_act, 12);

    d_if.enable = 1'b1;
    for (k = 0; k < 10 && !d_if.frame_start; k++) step();
    check("def_fs_found", d_if.frame_start, 1);
    hs_low = 0;
    for (int t = 0; t < 1700; t++) begin
      int h, v;
      bit a;
      h = t % 800; v = t / 800;
      a = (h < 640);
      if (t < 800 && !d_if.hs) hs_low++;
      check("def_cycle", pk(d_if.hs, d_if.vs, d_if.active, d_if.line_start, d_if.frame_start,
                            d_if.vblank, d_if.x, d_if.y),
            pk(!(h >= 656 && h <= 751), 1'b1, a, h == 0, t == 0, 1'b0,
               a ? 12'(h) : 12'd0, a ? 12'(v) : 12'd0));
      step();
    end
    check("def_hs_low_cnt", hs_low, 96);
    d_if.enable = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      s_if.cfg_we   = ($urandom_range(0, 5) == 0);
      s_if.cfg_addr = 3'($urandom_range(0, 7));
      s_if.cfg_data = 12'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 3) s_if.enable = ~s_if.enable;
    end
    @(negedge clock);
    s_if.cfg_we = 1'b0; s_if.enable = 1'b1;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, runtime-reconfigurable VGA/VESA raster timing generator. It produces hsync, vsync, active-video, pixel x/y and line/frame strobes from a single pixel clock. It supersedes the fixed 640x480 generator. Its eight timing fields reset to parameter defaults and can be rewritten over a small config port, taking effect only on a frame boundary. It sits between the pixel-clock domain and the framebuffer/text-mode pixel pipelines, which consume x/y/active.

## Interface
- CW, 12: width of each timing field and of x/y outputs; internal counters are CW+2 bits.
- H_ACT, 640: active pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACT, 480: active lines per frame.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- HS_POL, 0: asserted level of hs (0 = negative sync).
- VS_POL, 0: asserted level of vs.

Ports:
- clock  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run request; low holds the raster idle.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_addr  in  3  field select: 0 H_ACT, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACT, 5 V_FP, 6 V_SYNC, 7 V_BP.
- cfg_data  in  CW  field value.
- hs  out  1  horizontal sync, polarity per HS_POL.
- vs  out  1  vertical sync, polarity per VS_POL.
- active  out  1  pixel (x,y) is in the visible area.
- x  out  CW  horizontal pixel index.
- y  out  CW  vertical line index.
- line_start  out  1  first clock of each line.
- frame_start  out  1  first clock of each frame.
- vblank  out  1  v counter outside active lines.

## Operation
- Registers:
  - `run` (run <= enable);
  - h_cnt and v_cnt (CW+2 bits each);
  - shadow set of 8 fields, written by cfg;
  - working set of 8 fields, used by the counters.
- Line layout, h_cnt from 0: active [0, H_ACT-1], front porch, sync, back porch. H_TOT = H_ACT+H_FP+H_SYNC+H_BP, computed in CW+2 bits so there is no overflow. The frame layout is identical for v_cnt.
- Counting when run=1:
  - h_cnt increments every clock.
  - At h_cnt = H_TOT-1: h_cnt goes to 0 and v_cnt increments.
  - At v_cnt = V_TOT-1 on that same clock: v_cnt goes to 0.
- When run=0: h_cnt=v_cnt=0; the working set copies the shadow set every clock.
- Config:
  - cfg_we=1 writes cfg_data into shadow[cfg_addr].
  - A write of 0 is ignored; every field stays >= 1.
  - The working set loads from the shadow set on the frame-wrap clock (h=H_TOT-1, v=V_TOT-1), so the new timing applies starting at the next frame_start.
  - A write on the wrap clock itself is included in that load (write-through).
- Outputs are combinational from registered state only; there is no input-to-output path.
  - active = run & h_cnt<H_ACT & v_cnt<V_ACT.
  - x = active ? h_cnt[CW-1:0] : 0. y = active ? v_cnt[CW-1:0] : 0.
  - hs = HS_POL when run & h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1], otherwise ~HS_POL. vs is the same on v_cnt with VS_POL.
  - line_start = run & h_cnt==0. frame_start = line_start & v_cnt==0.
  - vblank = run & v_cnt>=V_ACT.
- Reset:
  - run=0; counters 0; both field sets = parameter defaults.
  - Outputs: hs=~HS_POL, vs=~VS_POL, active=0, x=y=0, line_start=frame_start=vblank=0.
- Reset mid-frame aborts the frame immediately and discards pending shadow writes.
- enable falling mid-frame: the raster goes idle on the next clock, and the next enable restarts at frame_start.

## Timing
- enable sampled high at edge k: run=1 after k. In that cycle frame_start=line_start=active=1 and x=y=0. x=1 after edge k+1.
- enable low at edge k: all outputs idle after edge k.
- cfg write effect latency: next frame_start (or immediate to the working set when run=0).
- Line period = H_TOT clocks; frame period = H_TOT*V_TOT clocks.
- x/y/active/hs/vs/strobes are mutually cycle-aligned: zero relative skew.

## Test plan
- Defaults, enable held from reset release:
  - Required: 800 clocks between line_starts and 420000 clocks between frame_starts.
  - hs low for h 656-751; vs low for lines 490-491; active count per frame = 307200.
- Small params (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1):
  - Required: x sequence 0,1,2,3,0,0,0,0 with active 1,1,1,1,0,0,0,0.
  - hs high at h=5,6; frame_start every 48 clocks; vblank on lines 3-5.
- Mid-frame cfg write H_ACT=6 at h=2,v=1 (small params):
  - Required: the current frame keeps H_TOT=8.
  - After the next frame_start, line period = 10 and active width = 6.
- Write cfg_data=0 to V_SYNC:
  - Required: ignored; vs width stays 1 line in the following frames.
- enable dropped at h=2,v=1, re-raised 3 clocks later:
  - Required: outputs idle on the next clock.
  - Restart produces frame_start=1 with x=y=0 one cycle after enable is sampled.
- reset_n low for 1 clock mid-frame after a pending shadow write:
  - Required: all outputs at reset values the next clock.
  - Timing reverts to parameter defaults.
